// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants and types for the downward-growing stack
package stack_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    // All-ones pointer value; sliced down to the instance address width
    localparam logic [31:0] SP_RESET = 32'hFFFF_FFFF;

    // Source feeding the pop_data output
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_BYP  = 2'd2
    } pop_sel_e;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - 1W/1R storage array with synchronous write and registered read
module stack_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Read register only moves on a read, so the last read value is held
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Array write and read register; a same-address read returns the old contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - LIFO stack with pointer, occupancy, sticky error flags and push/pop bypass
module stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [ADDR_W-1:0] sp,
    output logic              empty,
    output logic              full,
    output logic              err_ovf,
    output logic              err_udf
);

    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] SP_INIT  = SP_RESET[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] SP_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              pop_valid_q, pop_valid_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_udf_q, err_udf_d;
    pop_sel_e          pop_sel_q, pop_sel_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;

    logic              ovf_evt, udf_evt;
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] top_addr;
    logic [DATA_W-1:0] ram_rd_data;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_FULL);
    assign top_addr = sp_q + SP_ONE;

    // Next-state decode for push, pop, exchange and empty-stack bypass
    always_comb begin
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        pop_valid_d = 1'b0;
        pop_sel_d   = pop_sel_q;
        byp_data_d  = byp_data_q;
        wr_en       = 1'b0;
        wr_addr     = sp_q;
        rd_en       = 1'b0;
        ovf_evt     = 1'b0;
        udf_evt     = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (full) begin
                    ovf_evt = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q - SP_ONE;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            2'b01: begin
                if (empty) begin
                    udf_evt = 1'b1;
                end else begin
                    rd_en       = 1'b1;
                    sp_d        = top_addr;
                    cnt_d       = cnt_q - CNT_ONE;
                    pop_sel_d   = SEL_RAM;
                    pop_valid_d = 1'b1;
                end
            end
            2'b11: begin
                if (empty) begin
                    byp_data_d  = push_data;
                    pop_sel_d   = SEL_BYP;
                    pop_valid_d = 1'b1;
                end else begin
                    // Exchange the top entry: read-before-write at the same address
                    rd_en       = 1'b1;
                    wr_en       = 1'b1;
                    wr_addr     = top_addr;
                    pop_sel_d   = SEL_RAM;
                    pop_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
        err_ovf_d = ovf_evt | (err_ovf_q & ~err_clr);
        err_udf_d = udf_evt | (err_udf_q & ~err_clr);
    end

    // Pointer, occupancy, flags and pop-data source registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q        <= SP_INIT;
            cnt_q       <= '0;
            pop_valid_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
            pop_sel_q   <= SEL_ZERO;
            byp_data_q  <= '0;
        end else begin
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            pop_valid_q <= pop_valid_d;
            err_ovf_q   <= err_ovf_d;
            err_udf_q   <= err_udf_d;
            pop_sel_q   <= pop_sel_d;
            byp_data_q  <= byp_data_d;
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (push_data),
        .rd_en   (rd_en),
        .rd_addr (top_addr),
        .rd_data (ram_rd_data)
    );

    // Output data selects between registered sources; reset forces zero
    always_comb begin
        pop_data = '0;
        unique case (pop_sel_q)
            SEL_RAM: pop_data = ram_rd_data;
            SEL_BYP: pop_data = byp_data_q;
            default: pop_data = '0;
        endcase
    end

    assign pop_valid = pop_valid_q;
    assign sp        = sp_q;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_stack_mem.sv
// tb/tb_stack_mem.sv - self-checking bench for stack_mem against a queue-based LIFO model
module tb_stack_mem;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic       err_clr;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [2:0] sp;
    logic       empty;
    logic       full;
    logic       err_ovf;
    logic       err_udf;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] model_q[$];
    logic [7:0] m_pd  = 8'h00;
    logic       m_pv  = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    always #5 clk = ~clk;

    stack_mem #(
        .DATA_W (8),
        .ADDR_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .err_clr   (err_clr),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .err_ovf   (err_ovf),
        .err_udf   (err_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pointer: stack grows down from 7, one slot per stored entry
    function automatic logic [2:0] exp_sp();
        int n = model_q.size();
        return 3'((7 - n) & 7);
    endfunction

    task automatic check_all(input string tag, input bit chk_data);
        int n = model_q.size();
        check({tag, ":sp"},    32'(sp),        32'(exp_sp()));
        check({tag, ":empty"}, 32'(empty),     32'(n == 0));
        check({tag, ":full"},  32'(full),      32'(n == 8));
        check({tag, ":pv"},    32'(pop_valid), 32'(m_pv));
        check({tag, ":ovf"},   32'(err_ovf),   32'(m_ovf));
        check({tag, ":udf"},   32'(err_udf),   32'(m_udf));
        if (chk_data) begin
            check({tag, ":pd"}, 32'(pop_data), 32'(m_pd));
        end
    endtask

    // One clock of stimulus: drive on falling edge, update model, sample after rising edge
    task automatic step(input string tag, input bit p, input bit q, input logic [7:0] d, input bit clr);
        bit ev_o = 1'b0;
        bit ev_u = 1'b0;
        @(negedge clk);
        push = p; pop = q; push_data = d; err_clr = clr;
        m_pv = 1'b0;
        if (p && q) begin
            if (model_q.size() == 0) begin
                m_pd = d;
            end else begin
                m_pd = model_q[model_q.size()-1];
                model_q[model_q.size()-1] = d;
            end
            m_pv = 1'b1;
        end else if (p) begin
            if (model_q.size() == 8) ev_o = 1'b1;
            else model_q.push_back(d);
        end else if (q) begin
            if (model_q.size() == 0) ev_u = 1'b1;
            else begin
                m_pd = model_q.pop_back();
                m_pv = 1'b1;
            end
        end
        m_ovf = ev_o | (m_ovf & ~clr);
        m_udf = ev_u | (m_udf & ~clr);
        @(posedge clk);
        #1;
        check_all(tag, 1'b1);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_pd = 8'h00; m_pv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = 8'h00;
        rst = 1'b0;
        model_reset();
        #1;
        check_all(tag, 1'b1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int mode;
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = 8'h00;
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("reset0", 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic LIFO order and pointer walk
        step("p11", 1, 0, 8'h11, 0);
        step("p22", 1, 0, 8'h22, 0);
        step("p33", 1, 0, 8'h33, 0);
        step("pop33", 0, 1, 8'h00, 0);
        step("pop22", 0, 1, 8'h00, 0);
        step("pop11", 0, 1, 8'h00, 0);
        step("idle1", 0, 0, 8'h00, 0);

        // Fill to full with wrap, overflow, drain
        for (int i = 0; i < 8; i++) step("fill", 1, 0, 8'(i), 0);
        step("ovf", 1, 0, 8'hFF, 0);
        for (int i = 0; i < 8; i++) step("drain", 0, 1, 8'h00, 0);
        step("ovfclr", 0, 0, 8'h00, 1);

        // Underflow on fresh reset, then clear
        do_reset("reset1");
        step("udf", 0, 1, 8'h00, 0);
        step("hold", 0, 0, 8'h00, 0);
        step("udfclr", 0, 0, 8'h00, 1);
        step("udfset_clr", 0, 1, 8'h00, 1);
        step("udfclr2", 0, 0, 8'h00, 1);

        // Exchange on a non-empty stack
        step("pAA", 1, 0, 8'hAA, 0);
        step("pBB", 1, 0, 8'hBB, 0);
        step("xchgCC", 1, 1, 8'hCC, 0);
        step("popCC", 0, 1, 8'h00, 0);
        step("popAA", 0, 1, 8'h00, 0);

        // Bypass on an empty stack
        step("byp5A", 1, 1, 8'h5A, 0);
        step("idle2", 0, 0, 8'h00, 0);

        // Reset lands on an in-flight pop
        step("p77", 1, 0, 8'h77, 0);
        @(negedge clk);
        pop = 1'b1; push = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rstpop_async", 1'b1);
        @(posedge clk);
        #1;
        check_all("rstpop_edge", 1'b1);
        @(negedge clk);
        pop = 1'b0;
        rst = 1'b1;
        step("after_rst", 0, 0, 8'h00, 0);

        // Randomised traffic with phases biased toward filling or draining
        mode = 0;
        for (int i = 0; i < 800; i++) begin
            bit p, q, c;
            int r;
            if (i % 40 == 0) mode = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 99));
            case (mode)
                0: begin p = (r < 70); q = ($urandom_range(0, 99) < 30); end
                1: begin p = (r < 30); q = ($urandom_range(0, 99) < 70); end
                default: begin p = (r < 50); q = ($urandom_range(0, 99) < 50); end
            endcase
            c = ($urandom_range(0, 15) == 0);
            step("rand", p, q, 8'($urandom), c);
            if (i == 400) do_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
